// File: rtl/sd_pkg.sv
// Shared SD constants: command indices, response types, error codes and
// the fixed CMD8 / ACMD41 argument fields used by the init controller.
package sd_pkg;

  typedef logic [5:0] cmd_idx_t;

  localparam cmd_idx_t CMD_GO_IDLE         = 6'd0;
  localparam cmd_idx_t CMD_ALL_SEND_CID    = 6'd2;
  localparam cmd_idx_t CMD_SEND_RCA        = 6'd3;
  localparam cmd_idx_t CMD_SEND_IF_COND    = 6'd8;
  localparam cmd_idx_t CMD_SD_SEND_OP_COND = 6'd41;
  localparam cmd_idx_t CMD_APP_CMD         = 6'd55;

  localparam logic [1:0] RTYPE_NONE = 2'd0;
  localparam logic [1:0] RTYPE_R1   = 2'd1;
  localparam logic [1:0] RTYPE_R2   = 2'd2;
  localparam logic [1:0] RTYPE_R3   = 2'd3;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_CRC     = 3'd2;
  localparam logic [2:0] ERR_ECHO    = 3'd3;
  localparam logic [2:0] ERR_RETRIES = 3'd4;

  localparam logic [31:0] CMD8_ARG   = 32'h0000_01AA;
  localparam logic [11:0] CMD8_ECHO  = 12'h1AA;
  localparam logic [23:0] ACMD41_OCR = 24'hFF8000;

  // ACMD41 argument: HCS in bit 30, voltage window in [23:0].
  function automatic logic [31:0] acmd41_arg(input logic hcs);
    return {1'b0, hcs, 6'b0, ACMD41_OCR};
  endfunction

endpackage

// File: rtl/sd_init_ctrl_if.sv
// Command bus between the init controller (master) and the SD command
// engine (slave).
//
// Handshake: the master raises cmd_req with idx/arg/rtype and holds all four
// stable until it samples cmd_ack high; cmd_req drops the following cycle.
// The slave later returns a one-cycle cmd_done pulse; cmd_timeout,
// cmd_crc_err and resp are only meaningful in that cycle.
interface sd_init_ctrl_if;
  import sd_pkg::*;

  logic        cmd_req;
  logic        cmd_ack;
  cmd_idx_t    cmd_idx;
  logic [31:0] cmd_arg;
  logic [1:0]  cmd_rtype;
  logic        cmd_done;
  logic        cmd_timeout;
  logic        cmd_crc_err;
  logic [31:0] resp;

  modport master (
    output cmd_req, cmd_idx, cmd_arg, cmd_rtype,
    input  cmd_ack, cmd_done, cmd_timeout, cmd_crc_err, resp
  );

  modport slave (
    input  cmd_req, cmd_idx, cmd_arg, cmd_rtype,
    output cmd_ack, cmd_done, cmd_timeout, cmd_crc_err, resp
  );
endinterface

// File: rtl/sd_init_ctrl.sv
// SD card initialisation sequencer: CMD0, CMD8, (CMD55 + ACMD41 polled with
// a gap), CMD2, CMD3. Inside a command state the REQ phase is cmd_req_q=1
// and the WAIT phase is cmd_req_q=0. dbg_state_o = {cmd_req_q, state_q}.
module sd_init_ctrl
  import sd_pkg::*;
#(
  parameter int MAX_ACMD41_TRIES = 1000,
  parameter int POLL_GAP         = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        cmd_req_o,
  input  logic        cmd_ack_i,
  output logic [5:0]  cmd_idx_o,
  output logic [31:0] cmd_arg_o,
  output logic [1:0]  cmd_rtype_o,
  input  logic        cmd_done_i,
  input  logic        cmd_timeout_i,
  input  logic        cmd_crc_err_i,
  input  logic [31:0] resp_i,
  output logic        busy_o,
  output logic        ready_o,
  output logic        error_o,
  output logic [2:0]  err_code_o,
  output logic [5:0]  err_cmd_o,
  output logic [15:0] rca_o,
  output logic        ccs_o,
  output logic [4:0]  dbg_state_o
);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_CMD0   = 4'd1;
  localparam logic [3:0] ST_CMD8   = 4'd2;
  localparam logic [3:0] ST_CMD55  = 4'd3;
  localparam logic [3:0] ST_ACMD41 = 4'd4;
  localparam logic [3:0] ST_GAP    = 4'd5;
  localparam logic [3:0] ST_CMD2   = 4'd6;
  localparam logic [3:0] ST_CMD3   = 4'd7;
  localparam logic [3:0] ST_DONE   = 4'd8;
  localparam logic [3:0] ST_ERR    = 4'd9;

  localparam int TRY_W = $clog2(MAX_ACMD41_TRIES + 1);
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_ACMD41_TRIES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  logic [3:0]       state_q, state_d;
  logic             cmd_req_q, cmd_req_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [5:0]       err_cmd_q, err_cmd_d;
  logic [15:0]      rca_q, rca_d;
  logic             ccs_q, ccs_d;
  logic             hcs_q, hcs_d;
  logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
  logic [GAP_W-1:0] gap_q, gap_d;

  cmd_idx_t    cmd_idx;
  logic [31:0] cmd_arg;
  logic [1:0]  cmd_rtype;
  logic        wait_done;
  logic        err_hit;
  logic [2:0]  err_val;

  // Response bits the sequence never looks at.
  logic unused_resp;
  assign unused_resp = &{1'b0, resp_i[15:12]};

  // Command fields depend only on state (and hcs), so they hold through REQ.
  always_comb begin
    cmd_idx   = CMD_GO_IDLE;
    cmd_arg   = '0;
    cmd_rtype = RTYPE_NONE;
    case (state_q)
      ST_CMD8: begin
        cmd_idx   = CMD_SEND_IF_COND;
        cmd_arg   = CMD8_ARG;
        cmd_rtype = RTYPE_R1;
      end
      ST_CMD55: begin
        cmd_idx   = CMD_APP_CMD;
        cmd_rtype = RTYPE_R1;
      end
      ST_ACMD41: begin
        cmd_idx   = CMD_SD_SEND_OP_COND;
        cmd_arg   = acmd41_arg(hcs_q);
        cmd_rtype = RTYPE_R3;
      end
      ST_CMD2: begin
        cmd_idx   = CMD_ALL_SEND_CID;
        cmd_rtype = RTYPE_R2;
      end
      ST_CMD3: begin
        cmd_idx   = CMD_SEND_RCA;
        cmd_rtype = RTYPE_R1;
      end
      default: ;
    endcase
  end

  // Sequencer next-state: handshake, per-command result handling, error capture.
  always_comb begin
    state_d    = state_q;
    cmd_req_d  = cmd_req_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    err_cmd_d  = err_cmd_q;
    rca_d      = rca_q;
    ccs_d      = ccs_q;
    hcs_d      = hcs_q;
    tries_d    = tries_q;
    gap_d      = gap_q;
    err_hit    = 1'b0;
    err_val    = ERR_NONE;
    tries_inc  = (tries_q == TRY_MAX) ? tries_q : tries_q + 1'b1;
    wait_done  = cmd_done_i && !cmd_req_q;

    if (cmd_req_q && cmd_ack_i) cmd_req_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d    = ST_CMD0;
          cmd_req_d  = 1'b1;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          err_cmd_d  = '0;
          tries_d    = '0;
        end
      end
      ST_CMD0: begin
        if (wait_done) begin
          state_d   = ST_CMD8;
          cmd_req_d = 1'b1;
        end
      end
      ST_CMD8: begin
        if (wait_done) begin
          if (cmd_timeout_i) begin
            hcs_d     = 1'b0;
            state_d   = ST_CMD55;
            cmd_req_d = 1'b1;
          end else if (resp_i[11:0] != CMD8_ECHO) begin
            err_hit = 1'b1;
            err_val = ERR_ECHO;
          end else begin
            hcs_d     = 1'b1;
            state_d   = ST_CMD55;
            cmd_req_d = 1'b1;
          end
        end
      end
      ST_CMD55, ST_CMD2, ST_CMD3: begin
        if (wait_done) begin
          if (cmd_timeout_i) begin
            err_hit = 1'b1;
            err_val = ERR_TIMEOUT;
          end else if (cmd_crc_err_i) begin
            err_hit = 1'b1;
            err_val = ERR_CRC;
          end else if (state_q == ST_CMD55) begin
            state_d   = ST_ACMD41;
            cmd_req_d = 1'b1;
          end else if (state_q == ST_CMD2) begin
            state_d   = ST_CMD3;
            cmd_req_d = 1'b1;
          end else begin
            rca_d   = resp_i[31:16];
            state_d = ST_DONE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
          end
        end
      end
      ST_ACMD41: begin
        if (wait_done) begin
          tries_d = tries_inc;
          if (cmd_timeout_i) begin
            err_hit = 1'b1;
            err_val = ERR_TIMEOUT;
          end else if (resp_i[31]) begin
            ccs_d     = resp_i[30];
            state_d   = ST_CMD2;
            cmd_req_d = 1'b1;
          end else if (tries_inc == TRY_MAX) begin
            err_hit = 1'b1;
            err_val = ERR_RETRIES;
          end else begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d     = '0;
          state_d   = ST_CMD55;
          cmd_req_d = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_hit) begin
      state_d    = ST_ERR;
      busy_d     = 1'b0;
      error_d    = 1'b1;
      err_code_d = err_val;
      err_cmd_d  = cmd_idx;
    end
  end

  // State registers; reset wins over everything, even mid-request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cmd_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      err_cmd_q  <= '0;
      rca_q      <= '0;
      ccs_q      <= 1'b0;
      hcs_q      <= 1'b0;
      tries_q    <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_req_q  <= cmd_req_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      err_cmd_q  <= err_cmd_d;
      rca_q      <= rca_d;
      ccs_q      <= ccs_d;
      hcs_q      <= hcs_d;
      tries_q    <= tries_d;
      gap_q      <= gap_d;
    end
  end

  assign cmd_req_o   = cmd_req_q;
  assign cmd_idx_o   = cmd_idx;
  assign cmd_arg_o   = cmd_arg;
  assign cmd_rtype_o = cmd_rtype;
  assign busy_o      = busy_q;
  assign ready_o     = ready_q;
  assign error_o     = error_q;
  assign err_code_o  = err_code_q;
  assign err_cmd_o   = err_cmd_q;
  assign rca_o       = rca_q;
  assign ccs_o       = ccs_q;
  assign dbg_state_o = {cmd_req_q, state_q};

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Bench for sd_init_ctrl: table of card behaviours run through a small
// command-engine model, plus hand sequences for reset and restart cases.
module tb_sd_init_ctrl;
  localparam int MAX_TRIES = 4;
  localparam int GAP       = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        busy_o, ready_o, error_o, ccs_o;
  logic [2:0]  err_code_o;
  logic [5:0]  err_cmd_o;
  logic [15:0] rca_o;
  logic [4:0]  dbg_state_o;

  sd_init_ctrl_if bus();

  sd_init_ctrl #(.MAX_ACMD41_TRIES(MAX_TRIES), .POLL_GAP(GAP)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .cmd_req_o(bus.cmd_req), .cmd_ack_i(bus.cmd_ack),
    .cmd_idx_o(bus.cmd_idx), .cmd_arg_o(bus.cmd_arg), .cmd_rtype_o(bus.cmd_rtype),
    .cmd_done_i(bus.cmd_done), .cmd_timeout_i(bus.cmd_timeout),
    .cmd_crc_err_i(bus.cmd_crc_err), .resp_i(bus.resp),
    .busy_o(busy_o), .ready_o(ready_o), .error_o(error_o),
    .err_code_o(err_code_o), .err_cmd_o(err_cmd_o),
    .rca_o(rca_o), .ccs_o(ccs_o), .dbg_state_o(dbg_state_o)
  );

  // clock
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] cmd8_resp;
    int          acmd_busy;   // not-ready ACMD41 replies before the ready one
    logic        ccs;
    logic [31:0] cmd3_resp;
    logic [5:0]  f_idx;       // command that gets the fault flags
    logic        f_to;
    logic        f_crc;
    int          ack_dly;
    logic        stray;       // stray cmd_done during REQ
    logic        exp_ready;
    logic        exp_error;
    logic [2:0]  exp_code;
    logic [5:0]  exp_cmd;
    logic        exp_ccs;
    logic [15:0] exp_rca;
    int          exp_acmd;
    logic [31:0] exp_arg;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_rtype(input logic [5:0] idx);
    case (idx)
      6'd0:    return 2'd0;
      6'd2:    return 2'd2;
      6'd41:   return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  task automatic do_reset();
    bus.cmd_ack = 1'b0; bus.cmd_done = 1'b0; bus.cmd_timeout = 1'b0;
    bus.cmd_crc_err = 1'b0; bus.resp = '0; start_i = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Wait (bounded) for a request or for the sequence to end.
  task automatic wait_req(output int cyc, output bit got);
    cyc = 0;
    while (!bus.cmd_req && busy_o && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    got = bus.cmd_req;
  endtask

  // Engine model for one command whose request is already visible.
  task automatic serve_cmd(input logic to, input logic crc, input logic [31:0] resp,
                           input int dly, input logic stray);
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [1:0]  rt;
    idx = bus.cmd_idx; arg = bus.cmd_arg; rt = bus.cmd_rtype;
    for (int d = 0; d < dly; d++) begin
      if (d == 0 && stray) begin
        bus.cmd_done = 1'b1; bus.cmd_timeout = 1'b1;
      end
      @(posedge clk); #1;
      bus.cmd_done = 1'b0; bus.cmd_timeout = 1'b0;
      chk($sformatf("hold cmd%0d", idx), {bus.cmd_req, bus.cmd_idx, bus.cmd_rtype, bus.cmd_arg},
          {1'b1, idx, rt, arg});
    end
    bus.cmd_ack = 1'b1;
    @(posedge clk); #1;
    bus.cmd_ack = 1'b0;
    chk($sformatf("req drop cmd%0d", idx), bus.cmd_req, 1'b0);
    @(posedge clk); #1;
    bus.cmd_done = 1'b1; bus.cmd_timeout = to; bus.cmd_crc_err = crc; bus.resp = resp;
    @(posedge clk); #1;
    bus.cmd_done = 1'b0; bus.cmd_timeout = 1'b0; bus.cmd_crc_err = 1'b0; bus.resp = '0;
  endtask

  task automatic run_vec(input int k);
    vec_t        v;
    int          acmd_n, guard, cyc;
    bit          got;
    logic [5:0]  idx, last_idx;
    logic        to, crc;
    logic [31:0] resp, exp_a;
    v = vecs[k];
    do_reset();
    pulse_start();
    acmd_n = 0; guard = 0; last_idx = 6'h3F;
    while (busy_o && guard < 40) begin
      wait_req(cyc, got);
      if (!got) break;
      idx = bus.cmd_idx;
      chk($sformatf("v%0d rtype cmd%0d", k, idx), bus.cmd_rtype, exp_rtype(idx));
      if (idx == 6'd41) begin
        acmd_n++;
        exp_a = v.exp_arg;
      end else begin
        exp_a = (idx == 6'd8) ? 32'h0000_01AA : 32'h0;
      end
      chk($sformatf("v%0d arg cmd%0d", k, idx), bus.cmd_arg, exp_a);
      if (idx == 6'd55 && last_idx == 6'd41)
        chk($sformatf("v%0d gap cycles", k), cyc, GAP);
      to  = (idx == v.f_idx) && v.f_to;
      crc = (idx == v.f_idx) && v.f_crc;
      case (idx)
        6'd8:    resp = v.cmd8_resp;
        6'd41:   resp = (acmd_n > v.acmd_busy) ? {1'b1, v.ccs, 30'h00FF8000} : 32'h00FF8000;
        6'd3:    resp = v.cmd3_resp;
        default: resp = 32'h0;
      endcase
      serve_cmd(to, crc, resp, v.ack_dly, v.stray);
      last_idx = idx;
      guard++;
    end
    chk($sformatf("v%0d busy at end", k), busy_o, 1'b0);
    chk($sformatf("v%0d ready", k), ready_o, v.exp_ready);
    chk($sformatf("v%0d error", k), error_o, v.exp_error);
    chk($sformatf("v%0d err_code", k), err_code_o, v.exp_code);
    chk($sformatf("v%0d err_cmd", k), err_cmd_o, v.exp_cmd);
    chk($sformatf("v%0d ccs", k), ccs_o, v.exp_ccs);
    chk($sformatf("v%0d rca", k), rca_o, v.exp_rca);
    chk($sformatf("v%0d acmd41 count", k), acmd_n, v.exp_acmd);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " req"}, bus.cmd_req, 1'b0);
    chk({tag, " cmd fields"}, {bus.cmd_idx, bus.cmd_rtype, bus.cmd_arg}, 64'h0);
    chk({tag, " status"}, {busy_o, ready_o, error_o, err_code_o, err_cmd_o}, 64'h0);
    chk({tag, " rca/ccs"}, {rca_o, ccs_o}, 64'h0);
    chk({tag, " state"}, dbg_state_o, 5'd0);
  endtask

  initial begin
    //            cmd8     busy ccs cmd3         fidx  to crc dly st  rdy err code cmd  ccs rca       n  arg
    vecs[0]  = '{32'h1AA, 2,  1, 32'h12340000, 6'd63, 0, 0, 0, 0, 1, 0, 3'd0, 6'd0,  1, 16'h1234, 3, 32'h40FF8000};
    vecs[1]  = '{32'h000, 0,  0, 32'hABCD0000, 6'd8,  1, 0, 0, 0, 1, 0, 3'd0, 6'd0,  0, 16'hABCD, 1, 32'h00FF8000};
    vecs[2]  = '{32'h1AB, 0,  0, 32'h0,        6'd63, 0, 0, 0, 0, 0, 1, 3'd3, 6'd8,  0, 16'h0,    0, 32'h0};
    vecs[3]  = '{32'h1AA, 99, 0, 32'h0,        6'd63, 0, 0, 0, 0, 0, 1, 3'd4, 6'd41, 0, 16'h0,    4, 32'h40FF8000};
    vecs[4]  = '{32'h1AA, 0,  1, 32'h0,        6'd2,  0, 1, 0, 0, 0, 1, 3'd2, 6'd2,  1, 16'h0,    1, 32'h40FF8000};
    vecs[5]  = '{32'h1AA, 1,  0, 32'h55550000, 6'd63, 0, 0, 5, 1, 1, 0, 3'd0, 6'd0,  0, 16'h5555, 2, 32'h40FF8000};
    vecs[6]  = '{32'h1AA, 0,  0, 32'h0,        6'd55, 1, 0, 0, 0, 0, 1, 3'd1, 6'd55, 0, 16'h0,    0, 32'h0};
    vecs[7]  = '{32'h1AA, 0,  1, 32'h77770000, 6'd3,  1, 1, 2, 0, 0, 1, 3'd1, 6'd3,  1, 16'h0,    1, 32'h40FF8000};
    vecs[8]  = '{32'h1AA, 0,  1, 32'h00010000, 6'd0,  1, 0, 0, 0, 1, 0, 3'd0, 6'd0,  1, 16'h0001, 1, 32'h40FF8000};
    vecs[9]  = '{32'h1AA, 1,  0, 32'hFFFF0000, 6'd41, 0, 1, 1, 1, 1, 0, 3'd0, 6'd0,  0, 16'hFFFF, 2, 32'h40FF8000};
    vecs[10] = '{32'h1AA, 0,  0, 32'h0,        6'd55, 0, 1, 0, 0, 0, 1, 3'd2, 6'd55, 0, 16'h0,    0, 32'h0};
    vecs[11] = '{32'h1AA, 0,  0, 32'h0,        6'd41, 1, 0, 0, 0, 0, 1, 3'd1, 6'd41, 0, 16'h0,    1, 32'h40FF8000};

    // reset state
    do_reset();
    chk_all_zero("reset");

    for (int k = 0; k < 12; k++) run_vec(k);

    // restart from ERR without reset clears the error and starts CMD0
    pulse_start();
    chk("restart error cleared", {error_o, err_code_o, err_cmd_o}, 10'h0);
    chk("restart busy/req/idx", {busy_o, bus.cmd_req, bus.cmd_idx}, {1'b1, 1'b1, 6'd0});
    serve_cmd(1'b0, 1'b0, 32'h0, 0, 1'b0);
    // start while busy is ignored
    pulse_start();
    chk("start ignored while busy", {busy_o, bus.cmd_req, bus.cmd_idx}, {1'b1, 1'b1, 6'd8});
    serve_cmd(1'b0, 1'b0, 32'h1AA, 0, 1'b0);
    serve_cmd(1'b0, 1'b0, 32'h0, 0, 1'b0);
    chk("at acmd41 req", {bus.cmd_req, bus.cmd_idx}, {1'b1, 6'd41});
    bus.cmd_ack = 1'b1;
    @(posedge clk); #1;
    bus.cmd_ack = 1'b0;
    chk("acmd41 wait phase", {bus.cmd_req, bus.cmd_idx, busy_o}, {1'b0, 6'd41, 1'b1});
    // reset in ACMD41 WAIT takes effect on the next edge
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk_all_zero("mid reset");
    pulse_start();
    chk("post reset restart", {busy_o, bus.cmd_req, bus.cmd_idx, bus.cmd_rtype}, {1'b1, 1'b1, 6'd0, 2'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
